// File: rtl/shift_rx_pkg.sv
// Shared constants for the LED shift-pattern link (receive and transmit sides).
package shift_rx_pkg;

  localparam int unsigned DEF_WIDTH         = 4;
  localparam int unsigned DEF_TIMEOUT_WIDTH = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : shift_rx_pkg

// File: rtl/shift_rx_hold.sv
// Single-entry output holding register with valid/ready handshake and sticky overrun.
module shift_rx_hold
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  // A completion while the slot is being drained replaces the word without an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (i_load) begin
      if (!valid_q || i_ready) begin
        data_d  = i_word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;

endmodule : shift_rx_hold

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: frame-qualified bit strobes assembled into WIDTH-bit words.
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned MSB_FIRST     = 0,
  parameter int unsigned TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sdata,
  input  logic             i_sstb,
  input  logic             i_sframe,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  // Watchdog value one below all-ones: the next idle cycle is the timeout.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         sr_q, sr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     ferr_q, ferr_d;
  logic                     busy_q;
  logic [WIDTH-1:0]         shifted_c;
  logic [WIDTH-1:0]         first_c;
  logic                     load_c;

  // Bit placement: LSB-first shifts right from the top, MSB-first shifts left into bit 0.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted_c = {sr_q[WIDTH-2:0], i_sdata};
      first_c   = {{(WIDTH-1){1'b0}}, i_sdata};
    end else begin
      shifted_c = {i_sdata, sr_q[WIDTH-1:1]};
      first_c   = {i_sdata, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    ferr_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (i_sstb && i_sframe) begin
          sr_d    = first_c;
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_sstb) begin
          wd_d = '0;
          if (i_sframe) begin
            // Unexpected frame start: restart the word on this bit.
            ferr_d = 1'b1;
            sr_d   = first_c;
            cnt_d  = CNT_W'(1);
          end else if (cnt_q == CNT_LAST) begin
            load_c  = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sr_d  = shifted_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (wd_q == WD_LAST) begin
          ferr_d  = 1'b1;
          sr_d    = '0;
          cnt_d   = '0;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d == ST_SHIFT);
    end
  end

  shift_rx_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (load_c),
    .i_word    (shifted_c),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_overrun (o_overrun)
  );

  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule : shift_rx

// File: doc/shift_rx.md
Name: shift_rx

Overview:
Serial-to-parallel receiver for the LED shift-pattern link. It samples a serial data line on single-cycle bit strobes from the upstream shifter and assembles WIDTH-bit words, marked by a frame-start qualifier. Each complete word is presented on a valid/ready output port. It detects framing errors, inter-bit timeouts and overruns.

Parameters:
WIDTH, 4, bits per word (>=2)
MSB_FIRST, 0, 0: first received bit lands in o_data[0]; 1: first bit lands in o_data[WIDTH-1]
TIMEOUT_WIDTH, 8, width of the inter-bit watchdog counter; timeout after 2**TIMEOUT_WIDTH-1 cycles without a strobe

Ports:
i_clk  input  1  system clock; all logic on posedge
i_rst_n  input  1  asynchronous active-low reset
i_sdata  input  1  serial data; sampled only when i_sstb=1
i_sstb  input  1  bit strobe, one i_clk cycle wide
i_sframe  input  1  frame start; qualifies the first bit of a word (valid only with i_sstb=1)
i_ready  input  1  downstream accepts o_data when o_valid=1
o_data  output  WIDTH  received word, stable while o_valid=1
o_valid  output  1  word available
o_overrun  output  1  sticky; set when a completed word is dropped
o_frame_err  output  1  one-cycle pulse on framing error or timeout
o_busy  output  1  high while in SHIFT

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE; shift reg, bit count, watchdog=0; o_data=0, o_valid=0, o_overrun=0, o_frame_err=0, o_busy=0. Release is synchronous to i_clk.
- States: IDLE, SHIFT. Output holding register is separate from the shift register, so reception continues while o_valid=1.
- IDLE: i_sstb & i_sframe -> capture i_sdata as bit 0, count=1, go SHIFT. i_sstb & !i_sframe -> ignored.
- SHIFT: each i_sstb & !i_sframe -> shift in i_sdata, count+1, watchdog cleared.
- Bit placement: MSB_FIRST=0 shifts right with new bit at top; MSB_FIRST=1 shifts left with new bit at bit 0. The final word has the first bit at o_data[0] or o_data[WIDTH-1] respectively.
- Completion: the strobe carrying bit WIDTH-1 completes the word. State returns to IDLE.
  - If the holding register is free (o_valid=0), or being emptied the same cycle (o_valid & i_ready), load it. o_valid=1 and o_data = new word from the next cycle. Latency is 1 cycle after the last strobe.
  - Else (o_valid & !i_ready): drop the new word, keep the old, set o_overrun.
- Handshake: transfer on o_valid & i_ready. o_valid clears the next cycle unless a completion loads a new word that same cycle, in which case o_valid stays 1 with the new data. o_data must not change while o_valid=1 && !i_ready.
- Framing error: i_sstb & i_sframe while in SHIFT pulses o_frame_err. The partial word is discarded and reception restarts with this bit as bit 0 (count=1, stay SHIFT).
- Timeout: in SHIFT, the watchdog increments each cycle without i_sstb. On reaching all-ones: pulse o_frame_err, discard the partial word, go IDLE.
- Simultaneous events: i_sstb wins over timeout in the same cycle (the bit is accepted, the watchdog cleared). A completion and a handshake in the same cycle are not an overrun.
- o_overrun clears only on reset.
- o_busy = (state==SHIFT), registered.
- Reset mid-word or with o_valid=1: everything is discarded immediately.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_SHIFT) and the default WIDTH/TIMEOUT_WIDTH constants shared with the transmit-side shifter.
- One natural sub-module: shift_rx_hold, the single-entry output holding register with valid/ready, load and overrun logic. The FSM, shift register and watchdog stay in the top.

Test Plan:
- Reset with WIDTH=4, MSB_FIRST=0. Send bits 1,0,1,1 (sframe on first), one strobe every 3 cycles, i_ready=1 -> o_valid pulses 1 cycle after the 4th strobe with o_data=4'b1101; no errors.
- Same bits with MSB_FIRST=1 -> o_data=4'b1011.
- Hold i_ready=0, send two frames 0xA then 0x5 -> o_data stays 0xA, o_overrun=1. Raise i_ready -> 0xA consumed, o_valid drops, overrun remains 1.
- Assert i_ready in the exact cycle the second word completes -> o_valid stays 1, o_data changes to the second word, o_overrun=0.
- Send 2 bits, then i_sstb&i_sframe -> one-cycle o_frame_err. Then 3 more bits, e.g. bits 0,1,1,0 from the restart -> word 4'b0110.
- TIMEOUT_WIDTH=4: send 1 bit, then idle 15 cycles -> o_frame_err pulse, o_busy=0. Next non-frame strobe is ignored. Assert i_rst_n=0 mid-word -> all outputs 0 asynchronously.
